// File: rtl/cond_pkg.sv
// cond_pkg: condition-code encodings and NZCV flag bit positions
package cond_pkg;
  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_t;
  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;
endpackage

// File: rtl/cond_check.sv
// cond_check: evaluates a 4-bit condition field against registered NZCV flags
// Ports: cond (condition field), flags ({N,Z,C,V}), cond_ex (instruction executes)
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v, ge;
  assign n  = flags[N_IDX];
  assign z  = flags[Z_IDX];
  assign c  = flags[C_IDX];
  assign v  = flags[V_IDX];
  assign ge = n == v;
  always_comb begin
    cond_ex = 1'b0;
    case (cond_t'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = ~z;
      CS: cond_ex = c;
      CC: cond_ex = ~c;
      MI: cond_ex = n;
      PL: cond_ex = ~n;
      VS: cond_ex = v;
      VC: cond_ex = ~v;
      HI: cond_ex = c & ~z;
      LS: cond_ex = ~c | z;
      GE: cond_ex = ge;
      LT: cond_ex = ~ge;
      GT: cond_ex = ~z & ge;
      LE: cond_ex = z | ~ge;
      AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_logic.sv
// cond_logic: NZCV flag state, condition evaluation and write-enable gating
// Ports: clk, reset (sync, active-high); Cond, ALUFlags, FlagW, PCS, RegW, MemW,
//   NoWrite from the decoder/ALU; PCSrc, RegWrite, MemWrite enables; Flags state.
// Macro COND_PERF_EN adds ExecCount/SkipCount saturating counters of width CNT_W.
module cond_logic
  import cond_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags
`ifdef COND_PERF_EN
  ,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
`endif
);
  logic       cond_ex, live;
  logic [1:0] nz, cv;
  if (CNT_W < 1) begin : g_bad_width
    $error("cond_logic: CNT_W must be at least 1");
  end
  cond_check u_check (
    .cond   (Cond),
    .flags  (Flags),
    .cond_ex(cond_ex)
  );
  // enables are held low throughout reset whatever the decoder asks for
  assign live     = cond_ex & ~reset;
  assign PCSrc    = PCS & live;
  assign RegWrite = RegW & live & ~NoWrite;
  assign MemWrite = MemW & live;
  assign Flags    = {nz, cv};
  always_ff @(posedge clk) begin
    if (reset) nz <= 2'b00;
    else if (FlagW[1] & cond_ex) nz <= ALUFlags[N_IDX:Z_IDX];
  end
  always_ff @(posedge clk) begin
    if (reset) cv <= 2'b00;
    else if (FlagW[0] & cond_ex) cv <= ALUFlags[C_IDX:V_IDX];
  end
`ifdef COND_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ExecCount <= '0;
      SkipCount <= '0;
    end else if (cond_ex) ExecCount <= &ExecCount ? ExecCount : ExecCount + 1'b1;
    else SkipCount <= &SkipCount ? SkipCount : SkipCount + 1'b1;
  end
`endif
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: scoreboard bench for cond_logic with directed vectors
module tb_cond_logic;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Cond = 4'hE;
  logic [3:0] ALUFlags = 4'h0;
  logic [1:0] FlagW = 2'b00;
  logic       PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
  logic       PCSrc, RegWrite, MemWrite;
  logic [3:0] Flags;
  int         pass_cnt = 0, total_cnt = 0;
  string      qn[$];
  logic [6:0] qe[$];
  logic [3:0] cur;
  // bit f of entry c: whether condition c executes with flags {N,Z,C,V} = f
  logic [15:0] masks [16] = '{16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333,
                              16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555,
                              16'h0C0C, 16'hF3F3, 16'hAA55, 16'h55AA,
                              16'h0A05, 16'hF5FA, 16'hFFFF, 16'h0000};
  always #5 clk = ~clk;
`ifdef COND_PERF_EN
  logic [31:0] exec_cnt, skip_cnt;
  logic [3:0]  exec4, skip4;
  logic        p4, r4, m4;
  logic [3:0]  f4;
  cond_logic #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(p4), .RegWrite(r4), .MemWrite(m4), .Flags(f4),
    .ExecCount(exec4), .SkipCount(skip4)
  );
`endif
  cond_logic dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags)
`ifdef COND_PERF_EN
    , .ExecCount(exec_cnt), .SkipCount(skip_cnt)
`endif
  );
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  // exp = {PCSrc, RegWrite, MemWrite, Flags} seen during the cycle of this instruction
  task automatic step(input string nm, input logic r, input logic [3:0] c, input logic [3:0] af,
                      input logic [1:0] fw, input logic p, input logic rw, input logic mw,
                      input logic nw, input logic [6:0] exp);
    @(posedge clk);
    #1;
    reset = r; Cond = c; ALUFlags = af; FlagW = fw;
    PCS = p; RegW = rw; MemW = mw; NoWrite = nw;
    qn.push_back(nm);
    qe.push_back(exp);
  endtask
  always @(negedge clk) begin
    string      n;
    logic [6:0] e;
    if (qe.size() > 0) begin
      n = qn.pop_front();
      e = qe.pop_front();
      check(n, {25'd0, PCSrc, RegWrite, MemWrite, Flags}, {25'd0, e});
    end
  end
  initial begin
    step("reset_hold", 1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 7'b000_0000);
    step("reset_hold2", 1, 4'hE, 4'h3, 2'b11, 1, 1, 1, 0, 7'b000_0000);
    step("release", 0, 4'hE, 4'h0, 2'b00, 1, 1, 1, 0, 7'b111_0000);
    repeat (4) step("exec_idle", 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 7'b000_0000);
    repeat (3) step("nv_squash", 0, 4'hF, 4'hF, 2'b11, 1, 1, 1, 0, 7'b000_0000);
`ifdef COND_PERF_EN
    @(posedge clk);
    #1;
    check("exec_count_5", exec_cnt, 32'd5);
    check("skip_count_3", skip_cnt, 32'd3);
`endif
    step("flag_wr_all", 0, 4'hE, 4'h6, 2'b11, 0, 0, 0, 0, 7'b000_0000);
    step("flag_wr_nz", 0, 4'hE, 4'h9, 2'b10, 0, 0, 0, 0, 7'b000_0110);
    step("flag_hold_cv", 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 7'b000_1010);
    step("cmp_nowrite", 0, 4'hE, 4'h4, 2'b11, 0, 1, 0, 1, 7'b000_1010);
    step("beq_taken", 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 7'b100_0100);
    step("bne_not_taken", 0, 4'h1, 4'h0, 2'b00, 1, 0, 0, 0, 7'b000_0100);
    step("own_cond_old_flags", 0, 4'h0, 4'h0, 2'b11, 0, 1, 0, 0, 7'b010_0100);
    step("beq_after_clear", 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 7'b000_0000);
    step("squash", 0, 4'h0, 4'hF, 2'b11, 0, 1, 1, 0, 7'b000_0000);
    step("squash_flags_kept", 0, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0, 7'b100_0000);
    step("pre_reset_write", 0, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 7'b000_0000);
    step("mid_reset", 1, 4'hE, 4'h3, 2'b11, 1, 1, 1, 0, 7'b000_1111);
    step("mid_reset_cleared", 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 7'b000_0000);
    step("flag_wr_cv", 0, 4'hE, 4'hF, 2'b01, 0, 0, 0, 0, 7'b000_0000);
    step("cv_only", 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 7'b000_0011);
    cur = 4'b0011;
    for (int f = 0; f < 16; f++) begin
      step("set_flags", 0, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, {3'b000, cur});
      cur = 4'(f);
      for (int c = 0; c < 16; c++)
        step($sformatf("cond_%0d_flags_%0h", c, f), 0, 4'(c), 4'h0, 2'b00, 1, 0, 0, 0,
             {masks[c][f], 2'b00, cur});
    end
    step("reset_again", 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, {3'b000, cur});
    repeat (20) step("sat_run", 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 7'b000_0000);
`ifdef COND_PERF_EN
    @(posedge clk);
    #1;
    check("exec_count_20", exec_cnt, 32'd20);
    check("exec4_saturated", {28'd0, exec4}, 32'd15);
    check("skip4_zero", {28'd0, skip4}, 32'd0);
`endif
    for (int i = 0; i < 10 && qe.size() > 0; i++) @(negedge clk);
    #1;
    if (qe.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: got %0d pending expected 0", qe.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
